// File: rtl/adt7310_pkg.sv
// Shared constants and types for the ADT7310-style SPI slave.
package adt7310_pkg;

   // Register addresses
   localparam logic [2:0] ADDR_STATUS = 3'd0;
   localparam logic [2:0] ADDR_CONFIG = 3'd1;
   localparam logic [2:0] ADDR_TEMP   = 3'd2;

   // Command byte layout
   localparam int CMD_RD_BIT   = 6;
   localparam int CMD_ADDR_MSB = 5;
   localparam int CMD_ADDR_LSB = 3;

   // Config operating-mode field and the one-shot code
   localparam int         CFG_MODE_MSB  = 6;
   localparam int         CFG_MODE_LSB  = 5;
   localparam logic [1:0] MODE_ONE_SHOT = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMD,
      ST_WDATA,
      ST_RDATA
   } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with rise/fall detection on the synchronized level.
module spi_sync_edge #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   // [0],[1] are the synchronizer stages, [2] holds the previous synchronized level
   logic [2:0] sh_q, sh_d;

   // Shift the raw input through the chain
   always_comb begin
      sh_d = {sh_q[1:0], d_i};
   end

   // Chain register, reset to the line's idle level so no false edge appears
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) sh_q <= {3{RST_VAL}};
      else          sh_q <= sh_d;
   end

   assign q_o    = sh_q[1];
   assign rise_o =  sh_q[1] & ~sh_q[2];
   assign fall_o = ~sh_q[1] &  sh_q[2];

endmodule

// File: rtl/adt7310_spi_slave.sv
// SPI mode-3 slave with status/config/temperature registers and a one-shot
// conversion timer, all sampled in the Clk_i domain.
module adt7310_spi_slave
   import adt7310_pkg::*;
#(
   parameter int ConvDelay = 1000
) (
   input  logic        Clk_i,
   input  logic        Reset_n_i,
   input  logic        SPI_SCK_i,
   input  logic        SPI_CS_n_i,
   input  logic        SPI_MOSI_i,
   output logic        SPI_MISO_o,
   input  logic [15:0] Temperature_i,
   output logic [7:0]  Config_o,
   output logic        ConvBusy_o
);

   logic sck_lvl_unused, sck_rise, sck_fall;
   logic cs_s, cs_rise, cs_fall;
   logic [1:0] mosi_q, mosi_d;
   logic mosi_s;

   spi_sync_edge #(.RST_VAL(1'b1)) u_sck (
      .clk_i(Clk_i), .rst_n_i(Reset_n_i), .d_i(SPI_SCK_i),
      .q_o(sck_lvl_unused), .rise_o(sck_rise), .fall_o(sck_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
      .clk_i(Clk_i), .rst_n_i(Reset_n_i), .d_i(SPI_CS_n_i),
      .q_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
   );

   // MOSI needs only the level; same depth as SCK so data lines up with edges
   always_comb begin
      mosi_d = {mosi_q[0], SPI_MOSI_i};
   end

   // MOSI synchronizer
   always_ff @(posedge Clk_i) begin
      if (!Reset_n_i) mosi_q <= 2'b00;
      else            mosi_q <= mosi_d;
   end

   assign mosi_s = mosi_q[1];

   spi_state_e  state_q, state_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [4:0]  tx_cnt_q, tx_cnt_d;
   logic [15:0] shift_q, shift_d;
   logic [2:0]  addr_q, addr_d;
   logic        miso_q, miso_d;
   logic [7:0]  cfg_q, cfg_d;
   logic        rdy_n_q, rdy_n_d;
   logic [15:0] temp_q, temp_d;
   logic [15:0] cnt_q, cnt_d;
   logic        busy_q, busy_d;

   logic [7:0]  rx_byte;
   logic [2:0]  cmd_addr;
   logic [15:0] rd_val;
   logic [4:0]  rd_len;

   // Next state for transfer FSM, registers and conversion timer
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      tx_cnt_d  = tx_cnt_q;
      shift_d   = shift_q;
      addr_d    = addr_q;
      miso_d    = miso_q;
      cfg_d     = cfg_q;
      rdy_n_d   = rdy_n_q;
      temp_d    = temp_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;

      rx_byte  = {shift_q[6:0], mosi_s};
      cmd_addr = rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];

      // Read mux; 8-bit registers are left-justified in the 16-bit shifter
      rd_val = 16'h0000;
      rd_len = 5'd8;
      case (cmd_addr)
         ADDR_STATUS: rd_val = {rdy_n_q, 15'h0000};
         ADDR_CONFIG: rd_val = {cfg_q, 8'h00};
         ADDR_TEMP: begin
            rd_val = temp_q;  // old value even if conversion ends this cycle
            rd_len = 5'd16;
         end
         default: rd_val = 16'h0000;
      endcase

      // One-shot timer: busy drops in the cycle the counter reaches zero
      if (busy_q) begin
         if (cnt_q <= 16'd1) begin
            cnt_d   = 16'd0;
            busy_d  = 1'b0;
            temp_d  = Temperature_i;
            rdy_n_d = 1'b0;
         end else begin
            cnt_d = cnt_q - 16'd1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            miso_d = 1'b0;
            if (cs_fall) begin
               state_d   = ST_CMD;
               bit_cnt_d = 4'd0;
            end
         end
         ST_CMD: begin
            miso_d = 1'b0;
            if (sck_rise) begin
               shift_d   = {shift_q[14:0], mosi_s};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd7) begin
                  addr_d    = cmd_addr;
                  bit_cnt_d = 4'd0;
                  if (rx_byte[CMD_RD_BIT]) begin
                     state_d  = ST_RDATA;
                     shift_d  = rd_val;
                     tx_cnt_d = rd_len;
                  end else begin
                     state_d = ST_WDATA;
                  end
               end
            end
         end
         ST_WDATA: begin
            miso_d = 1'b0;
            // Only the first 8 data bits count; extra clocks are ignored
            if (sck_rise && bit_cnt_q < 4'd8) begin
               shift_d   = {shift_q[14:0], mosi_s};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd7 && addr_q == ADDR_CONFIG) begin
                  cfg_d = rx_byte;
                  // A one-shot write (re)starts the conversion, overriding the timer
                  if (rx_byte[CFG_MODE_MSB:CFG_MODE_LSB] == MODE_ONE_SHOT) begin
                     cnt_d   = 16'(ConvDelay);
                     busy_d  = 1'b1;
                     rdy_n_d = 1'b1;
                  end
               end
            end
         end
         ST_RDATA: begin
            if (sck_fall) begin
               if (tx_cnt_q != 5'd0) begin
                  miso_d   = shift_q[15];
                  shift_d  = {shift_q[14:0], 1'b0};
                  tx_cnt_d = tx_cnt_q - 5'd1;
                  if (tx_cnt_q == 5'd1 && addr_q == ADDR_TEMP) rdy_n_d = 1'b1;
               end else begin
                  miso_d = 1'b0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Deselect aborts whatever was in progress
      if (cs_rise || (cs_s && state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         miso_d  = 1'b0;
      end
   end

   // State and register flops
   always_ff @(posedge Clk_i) begin
      if (!Reset_n_i) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= 4'd0;
         tx_cnt_q  <= 5'd0;
         shift_q   <= 16'h0000;
         addr_q    <= 3'd0;
         miso_q    <= 1'b0;
         cfg_q     <= 8'h00;
         rdy_n_q   <= 1'b1;
         temp_q    <= 16'h0000;
         cnt_q     <= 16'd0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         tx_cnt_q  <= tx_cnt_d;
         shift_q   <= shift_d;
         addr_q    <= addr_d;
         miso_q    <= miso_d;
         cfg_q     <= cfg_d;
         rdy_n_q   <= rdy_n_d;
         temp_q    <= temp_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
      end
   end

   assign SPI_MISO_o = miso_q;
   assign Config_o   = cfg_q;
   assign ConvBusy_o = busy_q;

endmodule

// File: tb/tb_adt7310_spi_slave.sv
// Scoreboard bench: stimulus queues expected transfers and busy windows,
// bus and busy monitors pop and compare as the DUT presents them.
module tb_adt7310_spi_slave;

   localparam int CONV = 1000;

   logic        Clk_i = 1'b0;
   logic        Reset_n_i = 1'b0;
   logic        SPI_SCK_i = 1'b1;
   logic        SPI_CS_n_i = 1'b1;
   logic        SPI_MOSI_i = 1'b0;
   logic        SPI_MISO_o;
   logic [15:0] Temperature_i = 16'h0C80;
   logic [7:0]  Config_o;
   logic        ConvBusy_o;

   adt7310_spi_slave #(.ConvDelay(CONV)) dut (
      .Clk_i(Clk_i), .Reset_n_i(Reset_n_i),
      .SPI_SCK_i(SPI_SCK_i), .SPI_CS_n_i(SPI_CS_n_i), .SPI_MOSI_i(SPI_MOSI_i),
      .SPI_MISO_o(SPI_MISO_o), .Temperature_i(Temperature_i),
      .Config_o(Config_o), .ConvBusy_o(ConvBusy_o)
   );

   always #5 Clk_i = ~Clk_i;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge Clk_i) cyc <= cyc + 1;

   typedef struct {
      bit          rd;
      int          ndata;
      logic [15:0] data;
      logic [7:0]  cfg;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   busy_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one CS-low window, MSB first; rst_at >= 0 asserts reset before that bit
   task automatic spi_xfer(input logic [23:0] bits_v, input int nbits, input int rst_at);
      @(negedge Clk_i);
      SPI_CS_n_i = 1'b0;
      repeat (8) @(negedge Clk_i);
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_at) begin
            Reset_n_i = 1'b0;
            repeat (3) @(negedge Clk_i);
            check("rst_mid_miso", SPI_MISO_o, 0);
            check("rst_mid_cfg", Config_o, 0);
            check("rst_mid_busy", ConvBusy_o, 0);
            SPI_CS_n_i = 1'b1;
            repeat (3) @(negedge Clk_i);
            Reset_n_i = 1'b1;
            repeat (8) @(negedge Clk_i);
            return;
         end
         SPI_SCK_i  = 1'b0;
         SPI_MOSI_i = bits_v[23 - i];
         repeat (8) @(negedge Clk_i);
         SPI_SCK_i  = 1'b1;
         repeat (8) @(negedge Clk_i);
      end
      SPI_CS_n_i = 1'b1;
      repeat (16) @(negedge Clk_i);
   endtask

   task automatic rd(input logic [7:0] cmd, input int ndata, input logic [15:0] d,
                     input logic [7:0] cfg, input string nm);
      exp_t e;
      e.rd = 1'b1; e.ndata = ndata; e.data = d; e.cfg = cfg; e.name = nm;
      exp_q.push_back(e);
      spi_xfer({cmd, 16'h0000}, 8 + ndata, -1);
   endtask

   task automatic wr(input logic [7:0] cmd, input logic [7:0] data, input int nbits,
                     input logic [7:0] cfg, input string nm);
      exp_t e;
      e.rd = 1'b0; e.ndata = 0; e.data = 16'h0; e.cfg = cfg; e.name = nm;
      exp_q.push_back(e);
      spi_xfer({cmd, data, 8'h00}, nbits, -1);
   endtask

   task automatic wait_idle(input string nm);
      int k = 0;
      while (ConvBusy_o && k < 5000) begin
         @(negedge Clk_i);
         k++;
      end
      check(nm, ConvBusy_o, 0);
   endtask

   // Bus monitor: collects MISO on master sampling edges, checks at deselect
   initial begin : bus_mon
      logic [31:0] rx;
      logic [31:0] mask;
      int nb;
      exp_t e;
      forever begin
         @(negedge SPI_CS_n_i);
         rx = 0;
         nb = 0;
         forever begin
            @(posedge SPI_SCK_i or posedge SPI_CS_n_i);
            if (SPI_CS_n_i) break;
            rx = {rx[30:0], SPI_MISO_o};
            nb++;
         end
         repeat (4) @(negedge Clk_i);
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_xfer: got a transfer, expected none");
         end else begin
            e = exp_q.pop_front();
            if (e.rd) begin
               mask = (32'h1 << e.ndata) - 32'h1;
               check({e.name, "_bits"}, nb, 8 + e.ndata);
               check({e.name, "_data"}, rx & mask, {16'h0, e.data});
            end
            check({e.name, "_cfg"}, Config_o, {24'h0, e.cfg});
         end
      end
   end

   // Busy monitor: measures each high window of ConvBusy_o in clock cycles
   initial begin : busy_mon
      int n;
      n = 0;
      forever begin
         @(negedge Clk_i);
         if (ConvBusy_o) n++;
         else if (n > 0) begin
            if (busy_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_busy: got %0d busy cycles, expected none", n);
            end else begin
               check("busy_cycles", n, busy_q.pop_front());
            end
            n = 0;
         end
      end
   end

   initial begin : watchdog
      #(10 * 80000);
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int t0;
      exp_t e;
      repeat (5) @(negedge Clk_i);
      check("rst_cfg", Config_o, 0);
      check("rst_busy", ConvBusy_o, 0);
      check("rst_miso", SPI_MISO_o, 0);
      Reset_n_i = 1'b1;
      repeat (4) @(negedge Clk_i);

      // Status after reset, 16 clocks: 0x80 then zero padding
      rd(8'h40, 16, 16'h8000, 8'h00, "status_rst");
      rd(8'h78, 8, 16'h0000, 8'h00, "addr7");

      // One-shot: busy exactly CONV cycles, RDY_n clears
      busy_q.push_back(CONV);
      wr(8'h08, 8'h20, 16, 8'h20, "oneshot");
      wait_idle("conv1_done");
      rd(8'h40, 8, 16'h0000, 8'h20, "status_ready");
      rd(8'h50, 16, 16'h0C80, 8'h20, "temp");
      rd(8'h40, 8, 16'h0080, 8'h20, "status_after_temp");

      // Partial write discarded, next command decodes normally
      wr(8'h08, 8'hFF, 8 + 5, 8'h20, "abort_wr");
      rd(8'h48, 8, 16'h0020, 8'h20, "cfg_rd");

      // Restart 500 cycles in; a later plain write leaves the timer alone
      busy_q.push_back(CONV + 500);
      t0 = cyc;
      wr(8'h08, 8'h20, 16, 8'h20, "oneshot_a");
      while (cyc < t0 + 500) @(negedge Clk_i);
      wr(8'h08, 8'h20, 16, 8'h20, "oneshot_b");
      wr(8'h08, 8'h00, 16, 8'h00, "cfg_clr_running");
      wait_idle("conv2_done");

      wr(8'h08, 8'h1F, 16, 8'h1F, "cfg_plain");
      check("plain_no_conv", ConvBusy_o, 0);

      // Reset in the middle of a temperature read while MISO carries a 1
      e.rd = 1'b0; e.ndata = 0; e.data = 16'h0; e.cfg = 8'h00; e.name = "rst_mid_rd";
      exp_q.push_back(e);
      spi_xfer({8'h50, 16'h0000}, 24, 13);
      rd(8'h50, 16, 16'h0000, 8'h00, "temp_after_rst");
      rd(8'h40, 8, 16'h0080, 8'h00, "status_after_rst");

      repeat (50) @(negedge Clk_i);
      check("exp_q_drained", exp_q.size(), 0);
      check("busy_q_drained", busy_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/adt7310_spi_slave.md
ADT7310_SPI_SLAVE -- requirements
Module: adt7310_spi_slave

Interface
REQ-001 The block SHALL have parameter ConvDelay, default 1000, meaning Clk_i cycles from one-shot trigger to temperature register update (1..65535).
REQ-002 The block SHALL have one clock and a synchronous active-low reset; ports are listed below, clock and reset first.
REQ-003 Clk_i  in  1  system clock, all state on rising edge.
REQ-004 Reset_n_i  in  1  synchronous active-low reset.
REQ-005 SPI_SCK_i  in  1  SPI clock from master, mode 3 (CPOL=1, CPHA=1), asynchronous to Clk_i.
REQ-006 SPI_CS_n_i  in  1  chip select, active low, asynchronous.
REQ-007 SPI_MOSI_i  in  1  master-out data, asynchronous.
REQ-008 SPI_MISO_o  out  1  slave-out data, MSB first.
REQ-009 Temperature_i  in  16  sensor value captured at conversion end.
REQ-010 Config_o  out  8  current configuration register.
REQ-011 ConvBusy_o  out  1  high while a one-shot conversion runs.

Function
REQ-012 SCK, CS_n and MOSI SHALL each pass a 2-FF synchronizer; SCK edges SHALL be detected from the synchronized value; Clk_i SHALL be at least 8x SCK.
REQ-013 The FSM SHALL have states IDLE, CMD, WDATA, RDATA; synchronized CS_n falling moves IDLE->CMD with bit counter cleared.
REQ-014 In CMD, MOSI SHALL be sampled on each SCK rising edge; after 8 bits the command byte is decoded: bit6 = read (1) / write (0), bits5:3 = register address.
REQ-015 Register map: 0x0 status (8 bit, read only), 0x1 config (8 bit, R/W), 0x2 temperature (16 bit, read only); other addresses read 0x00 and ignore writes.
REQ-016 Read command: shift register SHALL load register content (8-bit registers left-justified) on the 8th rising edge; state -> RDATA.
REQ-017 In RDATA, MISO SHALL update on each SCK falling edge, the first falling edge after the command presenting the MSB; after the register width is exhausted MISO SHALL output 0.
REQ-018 Write command: state -> WDATA; 8 bits sampled on rising edges; config SHALL update on the 8th data bit only; further bits ignored until CS_n rises.
REQ-019 MISO SHALL be 0 in IDLE, CMD and WDATA.
REQ-020 Synchronized CS_n rising in any state SHALL return to IDLE within 1 cycle; partial command or data SHALL be discarded without register change.
REQ-021 A config write with bits6:5 = 01 SHALL start a one-shot: counter loaded with ConvDelay, ConvBusy_o high, status bit7 (RDY_n) set to 1.
REQ-022 The counter SHALL decrement each cycle; at 0 the temperature register SHALL capture Temperature_i, RDY_n SHALL clear to 0, ConvBusy_o SHALL fall in the same cycle.
REQ-023 A one-shot write during a running conversion SHALL reload the counter (restart); other config writes SHALL not affect a running conversion.
REQ-024 Completion of a temperature register read (16 bits shifted out) SHALL set RDY_n to 1.
REQ-025 Conversion end coinciding with a temperature read load SHALL let the load use the old value; the new value is visible on the next read.

Reset
REQ-026 Reset SHALL force state IDLE, SPI_MISO_o 0, Config_o 0x00, status 0x80, temperature register 0x0000, counter 0, ConvBusy_o 0, synchronizers to idle level (SCK 1, CS_n 1).
REQ-027 Reset mid-transfer or mid-conversion SHALL abort both; the transfer resumes only after a fresh CS_n falling edge.

Structure
REQ-028 Package adt7310_pkg SHALL hold register address constants, command bit positions (read bit, address field), one-shot mode code 01, and the FSM state enum.
REQ-029 One sub-module spi_sync_edge SHALL implement the 2-FF synchronizer plus rise/fall detect, instantiated for SCK and CS_n; MOSI uses its synchronized output only.

Verification
REQ-030 Write 0x08, 0x20 -> Config_o=0x20, ConvBusy_o high for exactly 1000 cycles, then status reads 0x00.
REQ-031 Temperature_i=0x0C80, one-shot complete, command 0x50 plus 16 clocks -> MISO returns 0x0C80 MSB first; the next status read returns 0x80.
REQ-032 Command 0x40 (read status) right after reset -> 0x80; command 0x78 (address 7) -> 0x00.
REQ-033 CS_n raised after 5 data bits of write 0x08, 0xFF -> Config_o unchanged, next command decoded normally.
REQ-034 Second one-shot written 500 cycles into a conversion -> ConvBusy_o stays high until 1000 cycles after the second write.
REQ-035 Reset_n_i low mid-read -> MISO 0, state IDLE, registers at reset values.
